// File: rtl/clk_freq_duty_meter.sv
// clk_freq_duty_meter
// Measures the rise-to-rise period and the high time of an asynchronous
// clock-like input in sampling-clock cycles. A restoring divider turns each
// measurement into an integer duty-cycle percentage.
//
// Ports
//   clk        : sampling clock (must run at least 2x faster than sig_in)
//   rst        : synchronous active-high reset
//   sig_in     : asynchronous signal under measurement
//   period     : last rise-to-rise interval in clk cycles
//   high_time  : clk cycles the synchronized input was high in that interval
//   meas_valid : one-cycle pulse when period/high_time update
//   duty_pct   : floor(high_time*100/period), 0..100
//   duty_valid : one-cycle pulse when duty_pct updates
//   busy       : divider running
//   overrun    : sticky; a measurement completed while the divider was busy
//   no_sig     : no rising edge seen for 2^CNT_W-1 cycles
module clk_freq_duty_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic [6:0]       duty_pct,
    output logic             duty_valid,
    output logic             busy,
    output logic             overrun,
    output logic             no_sig
);

    localparam int unsigned NUM_W  = CNT_W + 7;
    localparam int unsigned ITER_W = $clog2(NUM_W + 1);
    // Last count value before a counter would hit all-ones; reaching it
    // without an edge is the timeout, so counters never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [6:0]       PCT      = 7'd100;

    typedef enum logic {
        IDLE,
        MEASURE
    } meas_state_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_s;
    logic                   sig_d;
    logic                   rise;
    logic                   meas_done;

    meas_state_t            m_state;
    logic [CNT_W-1:0]       per_cnt;
    logic [CNT_W-1:0]       hi_cnt;

    div_state_t             d_state;
    logic [NUM_W-1:0]       quo;
    logic [CNT_W-1:0]       rem;
    logic [CNT_W-1:0]       dvsr;
    logic [ITER_W-1:0]      iter;
    logic [CNT_W:0]         rem_sh;
    logic [CNT_W:0]         rem_diff;
    logic                   q_bit;
    logic [NUM_W-1:0]       num_new;

    // Input synchronizer and one-cycle delay for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d  <= sig_s;
        end
    end

    assign sig_s     = sync_q[SYNC_STAGES-1];
    assign rise      = sig_s & ~sig_d;
    assign meas_done = (m_state == MEASURE) && rise;

    // Measure FSM: counts the interval between successive rising edges
    always_ff @(posedge clk) begin
        if (rst) begin
            m_state    <= IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            no_sig     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (m_state)
                IDLE: begin
                    // First edge only arms the counters; nothing to report yet
                    if (rise) begin
                        per_cnt <= CNT_W'(1);
                        hi_cnt  <= CNT_W'(1);
                        no_sig  <= 1'b0;
                        m_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period     <= per_cnt;
                        high_time  <= hi_cnt;
                        meas_valid <= 1'b1;
                        per_cnt    <= CNT_W'(1);
                        hi_cnt     <= CNT_W'(1);
                    end else if (per_cnt == CNT_LAST) begin
                        no_sig  <= 1'b1;
                        m_state <= IDLE;
                    end else begin
                        per_cnt <= per_cnt + CNT_W'(1);
                        hi_cnt  <= hi_cnt + CNT_W'(sig_s);
                    end
                end
                default: m_state <= IDLE;
            endcase
        end
    end

    // One restoring-division step: shift in the next numerator bit, subtract if it fits
    always_comb begin
        rem_sh   = {rem, quo[NUM_W-1]};
        rem_diff = rem_sh - {1'b0, dvsr};
        q_bit    = (rem_sh >= {1'b0, dvsr});
        num_new  = NUM_W'(hi_cnt) * NUM_W'(PCT);
    end

    // Divider FSM; operands are taken straight from the counters on the
    // measurement edge so the result lands CNT_W+8 cycles after meas_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_state    <= DIV_IDLE;
            quo        <= '0;
            rem        <= '0;
            dvsr       <= '0;
            iter       <= '0;
            duty_pct   <= '0;
            duty_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            case (d_state)
                DIV_RUN: begin
                    quo  <= {quo[NUM_W-2:0], q_bit};
                    rem  <= q_bit ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
                    iter <= iter + ITER_W'(1);
                    if (iter == ITER_W'(NUM_W - 1)) begin
                        d_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    duty_pct   <= quo[6:0];
                    duty_valid <= 1'b1;
                    busy       <= 1'b0;
                    d_state    <= DIV_IDLE;
                end
                default: ;
            endcase

            // A new measurement either starts a divide or is flagged as dropped
            if (meas_done) begin
                if (d_state == DIV_RUN) begin
                    overrun <= 1'b1;
                end else begin
                    quo     <= num_new;
                    rem     <= '0;
                    dvsr    <= per_cnt;
                    iter    <= '0;
                    busy    <= 1'b1;
                    d_state <= DIV_RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_freq_duty_meter.sv
// Directed bench for clk_freq_duty_meter: a CNT_W=16 instance for the
// measurement/divider scenarios and a CNT_W=8 instance for the timeouts.
module tb_clk_freq_duty_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Instance A (CNT_W = 16)
    logic        rst_a, sig_a;
    logic [15:0] period_a, high_a;
    logic        mv_a, dv_a, busy_a, ovr_a, nos_a;
    logic [6:0]  duty_a;

    // Instance B (CNT_W = 8)
    logic        rst_b, sig_b;
    logic [7:0]  period_b, high_b;
    logic        mv_b, dv_b, busy_b, ovr_b, nos_b;
    logic [6:0]  duty_b;

    clk_freq_duty_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst_a), .sig_in(sig_a),
        .period(period_a), .high_time(high_a), .meas_valid(mv_a),
        .duty_pct(duty_a), .duty_valid(dv_a), .busy(busy_a),
        .overrun(ovr_a), .no_sig(nos_a)
    );

    clk_freq_duty_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst_b), .sig_in(sig_b),
        .period(period_b), .high_time(high_b), .meas_valid(mv_b),
        .duty_pct(duty_b), .duty_valid(dv_b), .busy(busy_b),
        .overrun(ovr_b), .no_sig(nos_b)
    );

    // Waveform generators: high for hi_x cycles out of every per_x, driven on negedge
    int   per_a, hi_a, ph_a, per_b, hi_b, ph_b;
    bit   en_a, en_b;
    logic lvl_a, lvl_b;

    always @(negedge clk) begin
        if (en_a) begin
            sig_a = (ph_a < hi_a);
            ph_a  = ph_a + 1;
            if (ph_a >= per_a) ph_a = 0;
        end else begin
            sig_a = lvl_a;
        end
    end

    always @(negedge clk) begin
        if (en_b) begin
            sig_b = (ph_b < hi_b);
            ph_b  = ph_b + 1;
            if (ph_b >= per_b) ph_b = 0;
        end else begin
            sig_b = lvl_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       sel = mv_a;
            1:       sel = dv_a;
            2:       sel = mv_b;
            3:       sel = dv_b;
            4:       sel = nos_b;
            default: sel = 1'b0;
        endcase
    endfunction

    // Bounded wait; cyc = number of ticks until the event, -1 if it never came
    task automatic wait_for(input int which, input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if (sel(which) === 1'b1) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic start_a(input int per, input int hi);
        per_a = per; hi_a = hi; ph_a = 0; en_a = 1'b1;
    endtask

    task automatic start_b(input int per, input int hi);
        per_b = per; hi_b = hi; ph_b = 0; en_b = 1'b1;
    endtask

    task automatic reset_a();
        en_a = 1'b0; lvl_a = 1'b0;
        rst_a = 1'b1;
        tick(); tick();
        rst_a = 1'b0;
        tick();
    endtask

    task automatic reset_b();
        en_b = 1'b0; lvl_b = 1'b0;
        rst_b = 1'b1;
        tick(); tick();
        rst_b = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [37:0] obs_a;
        logic [29:0] obs_b;
        rst_a = 1'b1; rst_b = 1'b1;
        tick(); tick();
        obs_a = {period_a, high_a, mv_a, duty_a, dv_a, busy_a, ovr_a, nos_a};
        obs_b = {period_b, high_b, mv_b, duty_b, dv_b, busy_b, ovr_b, nos_b};
        n_checks++;
        if (obs_a !== '0) begin n_fail++; $display("FAIL reset_a: outputs=%h expected 0", obs_a); end
        n_checks++;
        if (obs_b !== '0) begin n_fail++; $display("FAIL reset_b: outputs=%h expected 0", obs_b); end
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
    endtask

    task automatic test_steady();
        int c;
        start_a(10, 7);
        // First rise only arms; meas at the second rise, 3 cycles of sync/edge latency
        wait_for(0, 40, c);
        n_checks++;
        if (c !== 13) begin n_fail++; $display("FAIL steady_first_meas: cycle=%0d expected 13", c); end
        n_checks++;
        if (period_a !== 16'd10 || high_a !== 16'd7) begin
            n_fail++; $display("FAIL steady_10_7: period=%0d high=%0d expected 10/7", period_a, high_a);
        end
        wait_for(1, 40, c);
        n_checks++;
        if (c !== 24) begin n_fail++; $display("FAIL steady_latency: cycles=%0d expected 24", c); end
        n_checks++;
        if (duty_a !== 7'd70) begin n_fail++; $display("FAIL steady_duty70: duty=%0d expected 70", duty_a); end
        wait_for(0, 20, c);
        wait_for(0, 20, c);
        n_checks++;
        if (c !== 10) begin n_fail++; $display("FAIL steady_meas_spacing: cycles=%0d expected 10", c); end
        n_checks++;
        if (ovr_a !== 1'b1) begin n_fail++; $display("FAIL steady_ovr_short: overrun=%0d expected 1", ovr_a); end

        reset_a();
        start_a(30, 21);
        wait_for(0, 60, c);
        n_checks++;
        if (c !== 33 || period_a !== 16'd30 || high_a !== 16'd21) begin
            n_fail++; $display("FAIL steady_30_21: cycle=%0d period=%0d high=%0d expected 33/30/21", c, period_a, high_a);
        end
        wait_for(1, 40, c);
        n_checks++;
        if (c !== 24 || duty_a !== 7'd70) begin
            n_fail++; $display("FAIL steady_30_duty: latency=%0d duty=%0d expected 24/70", c, duty_a);
        end
        for (int k = 0; k < 3; k++) wait_for(0, 40, c);
        n_checks++;
        if (c !== 30 || ovr_a !== 1'b0) begin
            n_fail++; $display("FAIL steady_30_no_ovr: spacing=%0d overrun=%0d expected 30/0", c, ovr_a);
        end
    endtask

    task automatic test_trunc_overrun();
        int c;
        reset_a();
        start_a(3, 1);
        wait_for(0, 20, c);
        n_checks++;
        if (c === -1 || period_a !== 16'd3 || high_a !== 16'd1 || ovr_a !== 1'b0) begin
            n_fail++; $display("FAIL trunc_first: cyc=%0d period=%0d high=%0d ovr=%0d expected 3/1/0", c, period_a, high_a, ovr_a);
        end
        wait_for(0, 10, c);
        n_checks++;
        if (c !== 3 || ovr_a !== 1'b1) begin
            n_fail++; $display("FAIL trunc_overrun: spacing=%0d ovr=%0d expected 3/1", c, ovr_a);
        end
        wait_for(1, 40, c);
        n_checks++;
        if (c !== 21 || duty_a !== 7'd33) begin
            n_fail++; $display("FAIL trunc_duty33: cyc=%0d duty=%0d expected 21/33", c, duty_a);
        end

        reset_a();
        start_a(40, 10);
        wait_for(0, 60, c);
        wait_for(1, 40, c);
        n_checks++;
        if (c !== 24 || duty_a !== 7'd25) begin
            n_fail++; $display("FAIL trunc_duty25: latency=%0d duty=%0d expected 24/25", c, duty_a);
        end
        wait_for(0, 60, c);
        n_checks++;
        if (c === -1 || ovr_a !== 1'b0 || period_a !== 16'd40 || high_a !== 16'd10) begin
            n_fail++; $display("FAIL trunc_40_no_ovr: cyc=%0d ovr=%0d period=%0d high=%0d expected 0/40/10", c, ovr_a, period_a, high_a);
        end
    endtask

    task automatic test_freq_change();
        int c;
        bit hit;
        reset_a();
        start_a(40, 20);
        wait_for(0, 60, c);
        n_checks++;
        if (c === -1 || period_a !== 16'd40 || high_a !== 16'd20) begin
            n_fail++; $display("FAIL freq_40_20: cyc=%0d period=%0d high=%0d expected 40/20", c, period_a, high_a);
        end
        // Switch during the low phase: that interval becomes 60 long with 20 high
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (ph_a == 30) hit = 1'b1;
            else tick();
        end
        per_a = 60; hi_a = 15;
        n_checks++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL freq_switch_point: reached=%0d expected 1", hit); end
        wait_for(0, 80, c);
        n_checks++;
        if (c === -1 || period_a !== 16'd60 || high_a !== 16'd20) begin
            n_fail++; $display("FAIL freq_mixed: cyc=%0d period=%0d high=%0d expected 60/20", c, period_a, high_a);
        end
        wait_for(1, 40, c);
        n_checks++;
        if (duty_a !== 7'd33) begin n_fail++; $display("FAIL freq_mixed_duty: duty=%0d expected 33", duty_a); end
        wait_for(0, 80, c);
        n_checks++;
        if (c !== 36 || period_a !== 16'd60 || high_a !== 16'd15) begin
            n_fail++; $display("FAIL freq_60_15: cyc=%0d period=%0d high=%0d expected 36/60/15", c, period_a, high_a);
        end
        wait_for(1, 40, c);
        n_checks++;
        if (c !== 24 || duty_a !== 7'd25) begin
            n_fail++; $display("FAIL freq_duty25: latency=%0d duty=%0d expected 24/25", c, duty_a);
        end
    endtask

    task automatic test_reset_mid_divide();
        int c;
        int n_dv;
        logic [37:0] obs;
        wait_for(0, 80, c);
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (busy_a !== 1'b1) begin n_fail++; $display("FAIL middiv_busy: busy=%0d expected 1", busy_a); end
        rst_a = 1'b1; en_a = 1'b0; lvl_a = 1'b0;
        tick();
        rst_a = 1'b0;
        obs = {period_a, high_a, mv_a, duty_a, dv_a, busy_a, ovr_a, nos_a};
        n_checks++;
        if (obs !== '0) begin n_fail++; $display("FAIL middiv_reset: outputs=%h expected 0", obs); end
        n_dv = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dv_a === 1'b1 || mv_a === 1'b1) n_dv++;
        end
        n_checks++;
        if (n_dv !== 0) begin n_fail++; $display("FAIL middiv_no_pulse: pulses=%0d expected 0", n_dv); end
        start_a(50, 25);
        wait_for(0, 80, c);
        n_checks++;
        if (c !== 53 || period_a !== 16'd50 || high_a !== 16'd25) begin
            n_fail++; $display("FAIL middiv_restart: cyc=%0d period=%0d high=%0d expected 53/50/25", c, period_a, high_a);
        end
        wait_for(1, 40, c);
        n_checks++;
        if (c !== 24 || duty_a !== 7'd50) begin
            n_fail++; $display("FAIL middiv_duty50: latency=%0d duty=%0d expected 24/50", c, duty_a);
        end
    endtask

    task automatic test_timeout();
        int c;
        int n_mv;
        reset_b();
        start_b(10, 5);
        wait_for(2, 40, c);
        n_checks++;
        if (c !== 13 || period_b !== 8'd10 || high_b !== 8'd5) begin
            n_fail++; $display("FAIL tmo_meas: cyc=%0d period=%0d high=%0d expected 13/10/5", c, period_b, high_b);
        end
        en_b = 1'b0; lvl_b = 1'b0;
        wait_for(4, 300, c);
        n_checks++;
        if (c !== 254) begin n_fail++; $display("FAIL tmo_delay: cycles=%0d expected 254", c); end
        n_checks++;
        if (period_b !== 8'd10 || high_b !== 8'd5 || duty_b !== 7'd50) begin
            n_fail++; $display("FAIL tmo_held: period=%0d high=%0d duty=%0d expected 10/5/50", period_b, high_b, duty_b);
        end
        start_b(20, 4);
        c = -1; n_mv = 0;
        for (int i = 1; i <= 10 && c == -1; i++) begin
            tick();
            if (mv_b === 1'b1) n_mv++;
            if (nos_b === 1'b0) c = i;
        end
        n_checks++;
        if (c !== 3 || n_mv !== 0) begin
            n_fail++; $display("FAIL tmo_resume: clear_cyc=%0d meas=%0d expected 3/0", c, n_mv);
        end
        wait_for(2, 40, c);
        n_checks++;
        if (c !== 20 || period_b !== 8'd20 || high_b !== 8'd4) begin
            n_fail++; $display("FAIL tmo_second_rise: cyc=%0d period=%0d high=%0d expected 20/20/4", c, period_b, high_b);
        end
        wait_for(3, 30, c);
        n_checks++;
        if (c !== 16 || duty_b !== 7'd20) begin
            n_fail++; $display("FAIL tmo_duty20: latency=%0d duty=%0d expected 16/20", c, duty_b);
        end
    endtask

    task automatic test_stuck_high();
        int n_mv;
        int nos_cyc;
        reset_b();
        lvl_b = 1'b1;
        n_mv = 0; nos_cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (mv_b === 1'b1) n_mv++;
            if (nos_b === 1'b1 && nos_cyc == -1) nos_cyc = i;
        end
        n_checks++;
        if (nos_cyc !== 257) begin n_fail++; $display("FAIL stuck_nosig: cycle=%0d expected 257", nos_cyc); end
        n_checks++;
        if (n_mv !== 0) begin n_fail++; $display("FAIL stuck_no_meas: meas=%0d expected 0", n_mv); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        sig_a = 1'b0; sig_b = 1'b0;
        en_a = 1'b0; en_b = 1'b0;
        lvl_a = 1'b0; lvl_b = 1'b0;
        per_a = 10; hi_a = 5; ph_a = 0;
        per_b = 10; hi_b = 5; ph_b = 0;

        test_reset();
        test_steady();
        test_trunc_overrun();
        test_freq_change();
        test_reset_mid_divide();
        test_timeout();
        test_stuck_high();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
